layer_sequencer: RTL and testbench

- Parametrised successor to the fixed start-decode top: a descriptor-driven sequencer that runs a programmed list of conv/fc layers back to back on the systolic array and accumulator/pool engine without host intervention per layer.
- Host loads a descriptor table, pulses go_i; the block drives the existing start encoding (0 wait, 1 SA, 2 FC) plus per-layer config, detects layer completion, and advances.
- Sits between host config registers and SA_TOP/ACC_POOL, replacing the host-held start/config inputs.

---
 rtl/layer_sequencer_if.sv | 30 +++
 rtl/layer_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
// Host-side control bus of the layer sequencer: descriptor table writes plus
// the go/abort pulses.
//   cfg_wren_i  : descriptor write strobe
//   cfg_addr_i  : descriptor index
//   cfg_wdata_i : descriptor word
//   go_i        : start the programmed sequence (pulse)
//   abort_i     : stop the running sequence (pulse)
// The host drives the bus (master); the sequencer receives it (slave).
// ---------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int MAX_LAYERS = 8
);
    localparam int AW = $clog2(MAX_LAYERS);

    logic          cfg_wren_i;
    logic [AW-1:0] cfg_addr_i;
    logic [31:0]   cfg_wdata_i;
    logic          go_i;
    logic          abort_i;

    modport master (
        output cfg_wren_i, cfg_addr_i, cfg_wdata_i, go_i, abort_i
    );

    modport slave (
        input cfg_wren_i, cfg_addr_i, cfg_wdata_i, go_i, abort_i
    );
endinterface

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Descriptor-driven sequencer that runs a programmed list of conv/fc layers
// back to back on the systolic array and accumulator/pool engine.
//   clk, rst          : clock, asynchronous active-high reset
//   cfg               : host bus (descriptor writes, go, abort)
//   pool_last_i       : per-pool last pulses (conv completion)
//   act_last_i        : fc activation last pulse (fc completion)
//   start_o           : engine start encoding (0 wait, 1 conv/SA, 2 fc)
//   nth_o .. out_node_num_o : per-layer config, latched in FETCH
//   cur_layer_o       : index of active / last layer
//   busy_o            : high whenever not idle
//   done_o            : one-cycle pulse when the sequence completes
//   err_o             : sticky error (1 illegal mode, 2 timeout, 3 aborted)
// Descriptor word: [1:0] mode, [3:2] nth, [8:4] ofmap_size, [14:9] ifmap_ch,
// [23:15] in_node_num, [30:24] out_node_num, [31] last.
// ---------------------------------------------------------------------------
module layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int NUM_POOL   = 16,
    parameter int GAP_CYCLES = 2,
    parameter int TMO_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    layer_sequencer_if.slave              cfg,
    input  logic [NUM_POOL-1:0]           pool_last_i,
    input  logic                          act_last_i,
    output logic [1:0]                    start_o,
    output logic [1:0]                    nth_o,
    output logic [4:0]                    ofmap_size_o,
    output logic [5:0]                    ifmap_ch_o,
    output logic [8:0]                    in_node_num_o,
    output logic [6:0]                    out_node_num_o,
    output logic [$clog2(MAX_LAYERS)-1:0] cur_layer_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    err_o
);
    localparam int AW = $clog2(MAX_LAYERS);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // One below all-ones: the cycle whose increment saturates the counter.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_GAP, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [1:0]          start_q, start_d;
    logic [1:0]          nth_q, nth_d;
    logic [4:0]          ofmap_q, ofmap_d;
    logic [5:0]          ifmap_q, ifmap_d;
    logic [8:0]          in_node_q, in_node_d;
    logic [6:0]          out_node_q, out_node_d;
    logic [AW-1:0]       cur_q, cur_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [1:0]          mode_q, mode_d;
    logic                last_q, last_d;
    logic [NUM_POOL-1:0] mask_q, mask_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [GW-1:0]       gap_q, gap_d;

    logic [31:0]         table_q [MAX_LAYERS];
    logic [31:0]         desc;
    logic [NUM_POOL-1:0] mask_now;
    logic                layer_done;
    logic                wr_en;

    // Table is only writable while idle so a running sequence never sees
    // its descriptors change underneath it.
    assign wr_en = cfg.cfg_wren_i && (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[cfg.cfg_addr_i] <= cfg.cfg_wdata_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        nth_d      = nth_q;
        ofmap_d    = ofmap_q;
        ifmap_d    = ifmap_q;
        in_node_d  = in_node_q;
        out_node_d = out_node_q;
        cur_d      = cur_q;
        done_d     = 1'b0;
        err_d      = err_q;
        mode_d     = mode_q;
        last_d     = last_q;
        mask_d     = mask_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;

        desc     = table_q[cur_q];
        // Completion includes pulses arriving in the current cycle.
        mask_now = mask_q | pool_last_i;
        layer_done = (mode_q == 2'd1) ? (&mask_now) : act_last_i;

        case (state_q)
            S_IDLE: begin
                if (cfg.go_i) begin
                    state_d = S_FETCH;
                    cur_d   = '0;
                    err_d   = 2'd0;
                end
            end
            S_FETCH: begin
                nth_d      = desc[3:2];
                ofmap_d    = desc[8:4];
                ifmap_d    = desc[14:9];
                in_node_d  = desc[23:15];
                out_node_d = desc[30:24];
                mode_d     = desc[1:0];
                last_d     = desc[31];
                if (cfg.abort_i) begin
                    err_d   = 2'd3;
                    state_d = S_ERR;
                end else if (desc[1:0] == 2'd1 || desc[1:0] == 2'd2) begin
                    start_d = desc[1:0];
                    mask_d  = '0;
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else begin
                    err_d   = 2'd1;
                    state_d = S_ERR;
                end
            end
            S_RUN: begin
                mask_d = mask_now;
                tmo_d  = tmo_q + 1'b1;
                // Abort beats completion, completion beats timeout.
                if (cfg.abort_i) begin
                    start_d = 2'd0;
                    err_d   = 2'd3;
                    state_d = S_ERR;
                end else if (layer_done) begin
                    start_d = 2'd0;
                    if (last_q || cur_q == AW'(MAX_LAYERS - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    start_d = 2'd0;
                    err_d   = 2'd2;
                    state_d = S_ERR;
                end
            end
            S_GAP: begin
                if (cfg.abort_i) begin
                    err_d   = 2'd3;
                    state_d = S_ERR;
                end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    cur_d   = cur_q + AW'(1);
                    state_d = S_FETCH;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_ERR: begin
                start_d = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                start_d = 2'd0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 2'd0;
            nth_q      <= 2'd0;
            ofmap_q    <= 5'd0;
            ifmap_q    <= 6'd0;
            in_node_q  <= 9'd0;
            out_node_q <= 7'd0;
            cur_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
            mode_q     <= 2'd0;
            last_q     <= 1'b0;
            mask_q     <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            nth_q      <= nth_d;
            ofmap_q    <= ofmap_d;
            ifmap_q    <= ifmap_d;
            in_node_q  <= in_node_d;
            out_node_q <= out_node_d;
            cur_q      <= cur_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
        end
    end

    assign start_o        = start_q;
    assign nth_o          = nth_q;
    assign ofmap_size_o   = ofmap_q;
    assign ifmap_ch_o     = ifmap_q;
    assign in_node_num_o  = in_node_q;
    assign out_node_num_o = out_node_q;
    assign cur_layer_o    = cur_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
// Scoreboarded bench: each sequence pushes its expected layer start values
// and its expected end state (done pulses, err, final layer); a monitor pops
// and compares them as start_o rises and as busy_o falls.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;
    localparam int ML  = 8;
    localparam int NP  = 16;
    localparam int GAP = 2;
    localparam int TW  = 8;
    localparam int AW  = 3;

    typedef struct packed {
        logic [7:0] done;
        logic [1:0] err;
        logic [2:0] cur;
    } seq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_sequencer_if #(.MAX_LAYERS(ML)) cfg_if ();

    logic [NP-1:0] pool_last;
    logic          act_last;
    logic [1:0]    start_o, nth_o, err_o;
    logic [4:0]    ofmap_size_o;
    logic [5:0]    ifmap_ch_o;
    logic [8:0]    in_node_num_o;
    logic [6:0]    out_node_num_o;
    logic [AW-1:0] cur_layer_o;
    logic          busy_o, done_o;

    layer_sequencer #(
        .MAX_LAYERS(ML), .NUM_POOL(NP), .GAP_CYCLES(GAP), .TMO_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if),
        .pool_last_i(pool_last), .act_last_i(act_last),
        .start_o(start_o), .nth_o(nth_o), .ofmap_size_o(ofmap_size_o),
        .ifmap_ch_o(ifmap_ch_o), .in_node_num_o(in_node_num_o),
        .out_node_num_o(out_node_num_o), .cur_layer_o(cur_layer_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    logic [1:0] start_q[$];
    seq_t       seq_q[$];

    function automatic seq_t mkseq(input int d, input int e, input int c);
        seq_t s;
        s.done = 8'(d);
        s.err  = 2'(e);
        s.cur  = 3'(c);
        return s;
    endfunction

    function automatic logic [31:0] mk(input int mode, input int nth, input int ofm,
                                       input int ch, input int innum, input int outnum,
                                       input bit last);
        return {last, 7'(outnum), 9'(innum), 6'(ch), 5'(ofm), 2'(nth), 2'(mode)};
    endfunction

    // Monitor: start values, inter-layer gap length, end-of-sequence state.
    int         done_cnt = 0, run_cnt = 0, zero_run = 0, last_run_len = 0;
    bit         seen_layer = 0;
    logic [1:0] prev_start = 2'd0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        seq_t e;
        if (done_o) done_cnt++;
        if (start_o != 2'd0) begin
            if (prev_start == 2'd0) begin
                if (start_q.size() == 0) chk("start_sb_empty", 1, 0);
                else chk("start_val", 32'(start_o), 32'(start_q.pop_front()));
                if (seen_layer) chk("gap_len", zero_run, GAP + 1);
            end
            run_cnt++;
            zero_run   = 0;
            seen_layer = 1;
        end else begin
            if (prev_start != 2'd0) begin
                last_run_len = run_cnt;
                run_cnt      = 0;
            end
            zero_run++;
        end
        if (prev_busy && !busy_o) begin
            seen_layer = 0;
            if (seq_q.size() == 0) begin
                chk("seq_sb_empty", 1, 0);
            end else begin
                e = seq_q.pop_front();
                chk("seq_done", done_cnt, 32'(e.done));
                chk("seq_err", 32'(err_o), 32'(e.err));
                chk("seq_cur", 32'(cur_layer_o), 32'(e.cur));
            end
            done_cnt = 0;
        end
        prev_start = start_o;
        prev_busy  = busy_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        cfg_if.cfg_wren_i  = 1'b1;
        cfg_if.cfg_addr_i  = AW'(idx);
        cfg_if.cfg_wdata_i = d;
        tick();
        cfg_if.cfg_wren_i  = 1'b0;
    endtask

    task automatic go();
        cfg_if.go_i = 1'b1;
        tick();
        cfg_if.go_i = 1'b0;
    endtask

    task automatic pool(input logic [NP-1:0] m);
        pool_last = m;
        tick();
        pool_last = '0;
    endtask

    task automatic act();
        act_last = 1'b1;
        tick();
        act_last = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (start_o == 2'd0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_start_bound", 32'(start_o != 2'd0), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", 32'(busy_o), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.cfg_wren_i  = 1'b0;
        cfg_if.cfg_addr_i  = '0;
        cfg_if.cfg_wdata_i = '0;
        cfg_if.go_i        = 1'b0;
        cfg_if.abort_i     = 1'b0;
        pool_last          = '0;
        act_last           = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_start", 32'(start_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_cur", 32'(cur_layer_o), 0);

        // 1: conv then fc, pool bits spread over three cycles.
        wr(0, mk(1, 0, 28, 1, 0, 0, 0));
        wr(1, mk(2, 0, 0, 0, 400, 120, 1));
        start_q.push_back(2'd1);
        start_q.push_back(2'd2);
        seq_q.push_back(mkseq(1, 0, 1));
        go();
        wait_start(10);
        chk("s1_ofmap", 32'(ofmap_size_o), 28);
        chk("s1_ch", 32'(ifmap_ch_o), 1);
        chk("s1_nth", 32'(nth_o), 0);
        chk("s1_busy", 32'(busy_o), 1);
        pool(16'h003F);
        pool(16'h07C0);
        chk("s1_conv_hold", 32'(start_o), 1);
        pool(16'hF800);
        chk("s1_conv_drop", 32'(start_o), 0);
        wait_start(10);
        chk("s1_in_node", 32'(in_node_num_o), 400);
        chk("s1_out_node", 32'(out_node_num_o), 120);
        chk("s1_cur", 32'(cur_layer_o), 1);
        act();
        wait_idle(10);

        // 2: pool bit 15 never arrives -> timeout after 255 RUN cycles.
        wr(0, mk(1, 1, 10, 3, 0, 0, 1));
        start_q.push_back(2'd1);
        seq_q.push_back(mkseq(0, 2, 0));
        go();
        wait_start(10);
        chk("s2_err_running", 32'(err_o), 0);
        pool(16'h7FFF);
        wait_idle(400);
        chk("s2_run_len", last_run_len, 255);

        // 3: illegal mode at L1 after a completed fc L0.
        wr(0, mk(2, 2, 0, 0, 10, 5, 0));
        wr(1, mk(3, 0, 0, 0, 0, 0, 1));
        start_q.push_back(2'd2);
        seq_q.push_back(mkseq(0, 1, 1));
        go();
        wait_start(10);
        chk("s3_nth", 32'(nth_o), 2);
        act();
        wait_idle(20);

        // 4: abort in the same cycle as fc completion.
        wr(0, mk(2, 0, 0, 0, 7, 9, 1));
        start_q.push_back(2'd2);
        seq_q.push_back(mkseq(0, 3, 0));
        go();
        wait_start(10);
        act_last       = 1'b1;
        cfg_if.abort_i = 1'b1;
        tick();
        act_last       = 1'b0;
        cfg_if.abort_i = 1'b0;
        chk("s4_start", 32'(start_o), 0);
        chk("s4_err", 32'(err_o), 3);
        chk("s4_busy_err", 32'(busy_o), 1);
        wait_idle(10);

        // 5: full table, no last bit; a stray go mid-sequence is ignored.
        for (int i = 0; i < ML; i++) begin
            wr(i, mk((i % 2) ? 2 : 1, i % 4, i + 3, i + 1, 100 + i, 50 + i, 0));
            start_q.push_back((i % 2) ? 2'd2 : 2'd1);
        end
        seq_q.push_back(mkseq(1, 0, 7));
        go();
        for (int i = 0; i < ML; i++) begin
            wait_start(10);
            chk("s5_cur", 32'(cur_layer_o), i);
            chk("s5_ofmap", 32'(ofmap_size_o), i + 3);
            if (i == 3) cfg_if.go_i = 1'b1;
            if (i % 2) act();
            else pool('1);
            cfg_if.go_i = 1'b0;
        end
        wait_idle(10);

        // 6: dropped write while busy, then async reset mid-RUN.
        wr(0, mk(1, 0, 28, 1, 0, 0, 1));
        start_q.push_back(2'd1);
        seq_q.push_back(mkseq(1, 0, 0));
        go();
        wait_start(10);
        wr(0, mk(2, 3, 5, 7, 1, 1, 1));
        chk("s6_ofmap_kept", 32'(ofmap_size_o), 28);
        chk("s6_start_kept", 32'(start_o), 1);
        pool('1);
        wait_idle(10);
        start_q.push_back(2'd1);
        seq_q.push_back(mkseq(0, 0, 0));
        go();
        wait_start(10);
        chk("s6_tbl_ofmap", 32'(ofmap_size_o), 28);
        chk("s6_tbl_nth", 32'(nth_o), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("s6_rst_start", 32'(start_o), 0);
        chk("s6_rst_busy", 32'(busy_o), 0);
        chk("s6_rst_ofmap", 32'(ofmap_size_o), 0);
        chk("s6_rst_ch", 32'(ifmap_ch_o), 0);
        chk("s6_rst_done", 32'(done_o), 0);
        tick();
        rst = 1'b0;
        tick();
        // Table was cleared by reset: layer 0 is now mode 0 -> illegal.
        seq_q.push_back(mkseq(0, 1, 0));
        go();
        wait_idle(10);
        chk("s6_start_q_drained", start_q.size(), 0);
        chk("s6_seq_q_drained", seq_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
